dpram_tdp_be: RTL and testbench
===============================

Name: dpram_tdp_be

Overview:
- Parametrised true dual-port RAM; successor to the fixed 16x4096 r2w1 dual-port RAM.
- Single clock domain.
- Both ports read and write, with per-byte write enables.
- Selectable read-during-write mode and an optional output register stage.
- Deterministic same-address collision handling with a collision flag, for shared buffers between two masters in the SoC fabric.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, byte-lane width; NB = DATA_W/BYTE_W lanes.
- ADDR_W, 12, address width; DEPTH = 2**ADDR_W words.
- OREG, 0, 1 adds an output register stage (read latency 2 instead of 1).
- RDW_MODE, 0, same-port read-during-write: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- a_ce  in  1  port A access enable.
- a_we  in  NB  port A per-lane write enable; write only when a_ce=1.
- a_addr  in  ADDR_W  port A word address.
- a_write  in  DATA_W  port A write data.
- a_read  out  DATA_W  port A read data.
- a_valid  out  1  a_read is valid this cycle.
- b_ce, b_we, b_addr, b_write, b_read, b_valid: same as port A, for port B.
- collision  out  1  pulse: same-address conflict detected.
- busy  out  1  clear engine active (see Optional Feature).

Behaviour:
- Reset values: a_read=0, b_read=0, a_valid=0, b_valid=0, collision=0.
  - Memory contents are not affected by reset.
  - Reset mid-operation drops all in-flight reads; no valid is produced for them.
- Accept and latency:
  - An access is accepted on an edge with x_ce=1 (and busy=0).
  - x_valid pulses exactly L cycles later, with L = 1+OREG.
  - Every accepted access produces one valid pulse, read or write, except as noted for NO_CHANGE.
  - Back-to-back accesses every cycle give full throughput.
- Same-port read-during-write (any x_we bit set):
  - READ_FIRST: x_read returns the old word.
  - WRITE_FIRST: x_read returns the merged word (new bytes where x_we=1, old bytes elsewhere).
  - NO_CHANGE: the data register holds its previous value and x_valid is not asserted for that access.
- Cross-port read of an address the other port writes in the same cycle:
  - Always returns the old word, regardless of RDW_MODE.
- Write-write collision (both accepted, a_addr==b_addr, both we nonzero):
  - Per lane: if both ports enable a lane, port A's data is written.
  - Lanes enabled by only one port take that port's data.
  - collision is asserted for one cycle on the edge after the conflict.
- Read-write on the same address across ports is not a collision; the flag stays 0.
- With OREG=1:
  - The second stage loads only when the first-stage valid is set.
  - x_read holds its value between valid pulses.
- Widths:
  - The address is used in full; no wrap logic is needed because DEPTH = 2**ADDR_W.
  - The top address (all ones) is a legal access.

Optional Feature:
- Macro: DPRAM_CLEAR_EN.
- Defined:
  - Clear state machine with states IDLE and CLEAR, and an ADDR_W-bit counter.
  - Reset forces CLEAR with counter=0; busy=1 while in CLEAR.
  - Each cycle in CLEAR writes 0 to the counter address and increments the counter.
  - After writing DEPTH-1, the state moves to IDLE and busy falls on the next edge. Clearing takes exactly DEPTH cycles after reset deasserts.
  - While busy=1, a_ce/b_ce are ignored: no writes, no valid, no collision.
  - Reset during CLEAR restarts the clear from address 0.
- Undefined:
  - No state machine; busy is tied 0.
  - Memory is uninitialised (X in simulation).
  - Ports are usable on the first cycle after reset.

Test Plan:
- Basic write then read, OREG=0: A writes 0x1234 at 0x005 (a_we=11), then A reads 0x005 → next cycle a_read=0x1234, a_valid=1. Repeat with OREG=1 → data arrives one cycle later.
- Byte enables: B writes 0xABCD at 0xFFF, then B writes 0x0011 with b_we=01 → B read of 0xFFF returns 0xAB11.
- Read-during-write with word 0x1111 at 0x010, A writes 0x2222 with a read at the same address:
  - RDW_MODE=0 → a_read=0x1111.
  - RDW_MODE=1 → a_read=0x2222.
  - RDW_MODE=2 → a_read unchanged and a_valid=0.
- Collision: A writes 0xAAAA with we=10, B writes 0x5555 with we=11, same cycle, addr 0x020 → collision pulses 1 cycle; stored word is 0xAA55. A write with B read at the same address → B gets old data, collision=0.
- Reset mid-flight, OREG=1: issue reads on both ports, assert reset on the next cycle → no valid pulses appear; outputs are 0.
- With DPRAM_CLEAR_EN and ADDR_W=4:
  - busy=1 for exactly 16 cycles after reset; accesses issued while busy produce no valid.
  - Afterwards every address reads 0.
  - Reset at cycle 8 → busy lasts 16 more cycles.

Source files
------------

// File: rtl/dpram_tdp_be.sv
// ---------------------------------------------------------------------------
// dpram_tdp_be -- parametrised true dual-port RAM with per-byte write enables
//
// Two symmetric ports (A and B) share one memory array in a single clock
// domain. Each port can read or write every cycle. Every accepted access
// (x_ce=1 while busy=0) yields one x_valid pulse 1+OREG cycles later, except
// a write in NO_CHANGE mode, which keeps the read data and gives no pulse.
//
// Parameters:
//   DATA_W   word width (multiple of BYTE_W)
//   BYTE_W   byte-lane width, NB = DATA_W/BYTE_W lanes
//   ADDR_W   address width, DEPTH = 2**ADDR_W words
//   OREG     1 adds an output register stage (read latency 2)
//   RDW_MODE same-port read-during-write: 0 READ_FIRST, 1 WRITE_FIRST,
//            2 NO_CHANGE
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   a_ce/a_we/a_addr/a_write   port A enable, lane write enables, addr, data
//   a_read/a_valid             port A read data and its valid pulse
//   b_*                        same for port B
//   collision                  one-cycle pulse after a same-address
//                              write-write conflict (port A wins shared lanes)
//   busy                       clear engine running; accesses are ignored
//
// Optional feature (macro DPRAM_CLEAR_EN): after reset a clear engine writes
// zero to every word, one per cycle, holding busy=1 for DEPTH cycles. Without
// the macro busy is tied low and memory starts uninitialised.
// ---------------------------------------------------------------------------
module dpram_tdp_be #(
    parameter int DATA_W   = 16,
    parameter int BYTE_W   = 8,
    parameter int ADDR_W   = 12,
    parameter int OREG     = 0,
    parameter int RDW_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_ce,
    input  logic [DATA_W/BYTE_W-1:0] a_we,
    input  logic [ADDR_W-1:0]        a_addr,
    input  logic [DATA_W-1:0]        a_write,
    output logic [DATA_W-1:0]        a_read,
    output logic                     a_valid,
    input  logic                     b_ce,
    input  logic [DATA_W/BYTE_W-1:0] b_we,
    input  logic [ADDR_W-1:0]        b_addr,
    input  logic [DATA_W-1:0]        b_write,
    output logic [DATA_W-1:0]        b_read,
    output logic                     b_valid,
    output logic                     collision,
    output logic                     busy
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy_int;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

`ifdef DPRAM_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} clr_state_t;

    clr_state_t        state_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
        end else if (state_reg == CLEAR) begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == {ADDR_W{1'b1}}) begin
                state_reg <= IDLE;
            end
        end
    end

    assign busy_int = (state_reg == CLEAR);
    assign clr_we   = (state_reg == CLEAR) && !reset;
    assign clr_addr = clr_cnt_reg;
`else
    assign busy_int = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    assign busy = busy_int;

    // Both ports packed into arrays so the read pipeline is generated once.
    logic              acc_p  [2];
    logic [NB-1:0]     we_p   [2];
    logic [ADDR_W-1:0] addr_p [2];
    logic [DATA_W-1:0] wr_p   [2];
    logic [DATA_W-1:0] rd_p   [2];
    logic              vld_p  [2];

    assign acc_p[0]  = a_ce & ~busy_int;
    assign acc_p[1]  = b_ce & ~busy_int;
    assign we_p[0]   = a_we;
    assign we_p[1]   = b_we;
    assign addr_p[0] = a_addr;
    assign addr_p[1] = b_addr;
    assign wr_p[0]   = a_write;
    assign wr_p[1]   = b_write;

    // Single write process: port B lanes first, port A lanes after, so on a
    // same-address conflict the later assignment (port A) owns shared lanes.
    // The clear engine only runs while both ports are locked out.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end
        for (int l = 0; l < NB; l++) begin
            if (acc_p[1] && we_p[1][l]) begin
                mem[addr_p[1]][l*BYTE_W +: BYTE_W] <= wr_p[1][l*BYTE_W +: BYTE_W];
            end
            if (acc_p[0] && we_p[0][l]) begin
                mem[addr_p[0]][l*BYTE_W +: BYTE_W] <= wr_p[0][l*BYTE_W +: BYTE_W];
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [DATA_W-1:0] old_word;
        logic [DATA_W-1:0] merged_word;
        logic [DATA_W-1:0] rd1_data_reg;
        logic              rd1_valid_reg;

        // Reads see the word as it was before this edge's writes, which is
        // what gives READ_FIRST and the old-data cross-port behaviour.
        assign old_word = mem[addr_p[gi]];

        always_comb begin
            merged_word = old_word;
            for (int l = 0; l < NB; l++) begin
                if (we_p[gi][l]) begin
                    merged_word[l*BYTE_W +: BYTE_W] = wr_p[gi][l*BYTE_W +: BYTE_W];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rd1_valid_reg <= 1'b0;
                rd1_data_reg  <= '0;
            end else begin
                rd1_valid_reg <= 1'b0;
                // NO_CHANGE writes leave the data register and valid untouched
                if (acc_p[gi] && !(RDW_MODE == 2 && (|we_p[gi]))) begin
                    rd1_valid_reg <= 1'b1;
                    rd1_data_reg  <= (RDW_MODE == 1 && (|we_p[gi])) ? merged_word : old_word;
                end
            end
        end

        if (OREG != 0) begin : g_oreg
            logic [DATA_W-1:0] rd2_data_reg;
            logic              rd2_valid_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rd2_valid_reg <= 1'b0;
                    rd2_data_reg  <= '0;
                end else begin
                    rd2_valid_reg <= rd1_valid_reg;
                    if (rd1_valid_reg) begin
                        rd2_data_reg <= rd1_data_reg;
                    end
                end
            end

            assign rd_p[gi]  = rd2_data_reg;
            assign vld_p[gi] = rd2_valid_reg;
        end else begin : g_noreg
            assign rd_p[gi]  = rd1_data_reg;
            assign vld_p[gi] = rd1_valid_reg;
        end
    end

    assign a_read  = rd_p[0];
    assign a_valid = vld_p[0];
    assign b_read  = rd_p[1];
    assign b_valid = vld_p[1];

    // Only write-write on one address is a conflict; read-write is not.
    logic collision_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            collision_reg <= 1'b0;
        end else begin
            collision_reg <= acc_p[0] && acc_p[1] && (addr_p[0] == addr_p[1])
                             && (|we_p[0]) && (|we_p[1]);
        end
    end

    assign collision = collision_reg;

endmodule

// File: tb/tb_dpram_tdp_be.sv
// ---------------------------------------------------------------------------
// tb_dpram_tdp_be -- self-checking bench for dpram_tdp_be
//
// Three instances share one stimulus stream:
//   inst 0: OREG=0 READ_FIRST, inst 1: OREG=1 WRITE_FIRST, inst 2: OREG=0
//   NO_CHANGE. A directed vector table checks inst 0, short hand-written
// sequences cover latency, read-during-write modes and reset mid-flight, and
// a randomized phase checks all instances against a behavioural model.
// ---------------------------------------------------------------------------
module tb_dpram_tdp_be;

    localparam int AW    = 12;
    localparam int DEPTH = 2 ** AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_ce, b_ce;
    logic [1:0]  a_we, b_we;
    logic [11:0] a_addr, b_addr;
    logic [15:0] a_write, b_write;

    logic [15:0] o_ar [3];
    logic [15:0] o_br [3];
    logic        o_av [3];
    logic        o_bv [3];
    logic        o_col [3];
    logic        o_busy [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        dpram_tdp_be #(
            .DATA_W   (16),
            .BYTE_W   (8),
            .ADDR_W   (AW),
            .OREG     ((gi == 1) ? 1 : 0),
            .RDW_MODE (gi)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .a_ce      (a_ce),
            .a_we      (a_we),
            .a_addr    (a_addr),
            .a_write   (a_write),
            .a_read    (o_ar[gi]),
            .a_valid   (o_av[gi]),
            .b_ce      (b_ce),
            .b_we      (b_we),
            .b_addr    (b_addr),
            .b_write   (b_write),
            .b_read    (o_br[gi]),
            .b_valid   (o_bv[gi]),
            .collision (o_col[gi]),
            .busy      (o_busy[gi])
        );
    end

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    localparam int MODE_OF [3] = '{0, 1, 2};
    localparam int LAT2_OF [3] = '{0, 1, 0};

    logic [15:0] mmem [int];
    int          clr_left = 0;
    logic [15:0] m_hold [3][2];
    logic        m_pv   [3][2];
    logic [15:0] m_pd   [3][2];
    logic        m_ev   [3][2];
    logic        m_col;

    function automatic logic [15:0] mread(input int addr);
        return mmem.exists(addr) ? mmem[addr] : 16'h0000;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wr,
                                          input logic [1:0] we);
        logic [15:0] r;
        r = old;
        if (we[0]) r[7:0]  = wr[7:0];
        if (we[1]) r[15:8] = wr[15:8];
        return r;
    endfunction

    task automatic model_step();
        logic        ce [2];
        logic [1:0]  we [2];
        int          ad [2];
        logic [15:0] wr [2];
        logic [15:0] old [2];
        logic        s1v, ov, busy_now;
        logic [15:0] s1d, od;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int p = 0; p < 2; p++) begin
                    m_hold[i][p] = 16'h0;
                    m_pv[i][p]   = 1'b0;
                    m_pd[i][p]   = 16'h0;
                    m_ev[i][p]   = 1'b0;
                end
            end
            m_col = 1'b0;
`ifdef DPRAM_CLEAR_EN
            mmem.delete();
            clr_left = DEPTH;
`endif
            return;
        end
        busy_now = (clr_left != 0);
        if (busy_now) clr_left--;
        ce[0] = a_ce && !busy_now;  ce[1] = b_ce && !busy_now;
        we[0] = a_we;   we[1] = b_we;
        ad[0] = int'(a_addr); ad[1] = int'(b_addr);
        wr[0] = a_write; wr[1] = b_write;
        old[0] = mread(ad[0]); old[1] = mread(ad[1]);
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 2; p++) begin
                s1v = ce[p] && !(MODE_OF[i] == 2 && we[p] != 2'b00);
                s1d = (MODE_OF[i] == 1 && we[p] != 2'b00) ? merge(old[p], wr[p], we[p]) : old[p];
                if (LAT2_OF[i] != 0) begin
                    ov = m_pv[i][p]; od = m_pd[i][p];
                    m_pv[i][p] = s1v;
                    if (s1v) m_pd[i][p] = s1d;
                end else begin
                    ov = s1v; od = s1d;
                end
                m_ev[i][p] = ov;
                if (ov) m_hold[i][p] = od;
            end
        end
        m_col = ce[0] && ce[1] && (ad[0] == ad[1]) && (we[0] != 2'b00) && (we[1] != 2'b00);
        // B applied first, then A on top: A owns lanes both ports enable
        for (int p = 1; p >= 0; p--) begin
            if (ce[p] && we[p] != 2'b00) mmem[ad[p]] = merge(mread(ad[p]), wr[p], we[p]);
        end
    endtask

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_a(input logic ce, input logic [1:0] we, input logic [11:0] ad, input logic [15:0] d);
        a_ce = ce; a_we = we; a_addr = ad; a_write = d;
    endtask

    task automatic set_b(input logic ce, input logic [1:0] we, input logic [11:0] ad, input logic [15:0] d);
        b_ce = ce; b_we = we; b_addr = ad; b_write = d;
    endtask

    task automatic idle();
        set_a(1'b0, 2'b00, 12'h000, 16'h0000);
        set_b(1'b0, 2'b00, 12'h000, 16'h0000);
    endtask

    // Called with reset already released; start = cycles already spent.
    task automatic wait_clear(input int start);
`ifdef DPRAM_CLEAR_EN
        int n;
        n = start;
        set_a(1'b1, 2'b00, 12'h005, 16'h0000);
        set_b(1'b1, 2'b00, 12'hFFF, 16'h0000);
        while (o_busy[0] === 1'b1 && n < DEPTH + 8) begin
            step();
            n++;
            chk("busy_no_a_valid", 32'(o_av[0]), 32'd0);
            chk("busy_no_b_valid", 32'(o_bv[0]), 32'd0);
        end
        idle();
        chk("clear_cycles", n, DEPTH);
`else
        chk($sformatf("busy_low_%0d", start), 32'(o_busy[0]), 32'd0);
`endif
    endtask

    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rnd_a_valid_i%0d", i), 32'(o_av[i]), 32'(m_ev[i][0]));
            chk($sformatf("rnd_a_read_i%0d", i),  32'(o_ar[i]), 32'(m_hold[i][0]));
            chk($sformatf("rnd_b_valid_i%0d", i), 32'(o_bv[i]), 32'(m_ev[i][1]));
            chk($sformatf("rnd_b_read_i%0d", i),  32'(o_br[i]), 32'(m_hold[i][1]));
            chk($sformatf("rnd_collision_i%0d", i), 32'(o_col[i]), 32'(m_col));
            chk($sformatf("rnd_busy_i%0d", i), 32'(o_busy[i]), 32'(clr_left != 0));
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table (expected values for instance 0)
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        a_ce;
        logic [1:0]  a_we;
        logic [11:0] a_addr;
        logic [15:0] a_wr;
        logic        b_ce;
        logic [1:0]  b_we;
        logic [11:0] b_addr;
        logic [15:0] b_wr;
        logic        e_av;
        logic        chk_ar;
        logic [15:0] e_ar;
        logic        e_bv;
        logic        chk_br;
        logic [15:0] e_br;
        logic        e_col;
    } vec_t;

    function automatic vec_t mk(input logic ac, input logic [1:0] aw, input logic [11:0] aa,
                                input logic [15:0] ad, input logic bc, input logic [1:0] bw,
                                input logic [11:0] ba, input logic [15:0] bd, input logic eav,
                                input logic car, input logic [15:0] ear, input logic ebv,
                                input logic cbr, input logic [15:0] ebr, input logic ecol);
        vec_t v;
        v = '{ac, aw, aa, ad, bc, bw, ba, bd, eav, car, ear, ebv, cbr, ebr, ecol};
        return v;
    endfunction

    vec_t vt [18];

    initial begin
        logic [11:0] pool [7];
        pool = '{12'h005, 12'h010, 12'h020, 12'h040, 12'h050, 12'h051, 12'hFFF};

        vt[0]  = mk(1, 2'b11, 12'h005, 16'h1234, 0, 2'b00, 12'h000, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0000, 0);
        vt[1]  = mk(1, 2'b00, 12'h005, 16'h0000, 0, 2'b00, 12'h000, 16'h0000, 1, 1, 16'h1234, 0, 1, 16'h0000, 0);
        vt[2]  = mk(0, 2'b00, 12'h000, 16'h0000, 1, 2'b11, 12'hFFF, 16'hABCD, 0, 1, 16'h1234, 1, 0, 16'h0000, 0);
        vt[3]  = mk(0, 2'b00, 12'h000, 16'h0000, 1, 2'b01, 12'hFFF, 16'h0011, 0, 1, 16'h1234, 1, 1, 16'hABCD, 0);
        vt[4]  = mk(0, 2'b00, 12'h000, 16'h0000, 1, 2'b00, 12'hFFF, 16'h0000, 0, 1, 16'h1234, 1, 1, 16'hAB11, 0);
        vt[5]  = mk(1, 2'b11, 12'h010, 16'h1111, 0, 2'b00, 12'h000, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'hAB11, 0);
        vt[6]  = mk(1, 2'b11, 12'h010, 16'h2222, 0, 2'b00, 12'h000, 16'h0000, 1, 1, 16'h1111, 0, 1, 16'hAB11, 0);
        vt[7]  = mk(1, 2'b00, 12'h010, 16'h0000, 0, 2'b00, 12'h000, 16'h0000, 1, 1, 16'h2222, 0, 1, 16'hAB11, 0);
        vt[8]  = mk(1, 2'b10, 12'h020, 16'hAAAA, 1, 2'b11, 12'h020, 16'h5555, 1, 0, 16'h0000, 1, 0, 16'h0000, 1);
        vt[9]  = mk(1, 2'b00, 12'h020, 16'h0000, 0, 2'b00, 12'h000, 16'h0000, 1, 1, 16'hAA55, 0, 0, 16'h0000, 0);
        vt[10] = mk(1, 2'b11, 12'h020, 16'h7777, 1, 2'b00, 12'h020, 16'h0000, 1, 1, 16'hAA55, 1, 1, 16'hAA55, 0);
        vt[11] = mk(0, 2'b00, 12'h000, 16'h0000, 1, 2'b00, 12'h020, 16'h0000, 0, 1, 16'hAA55, 1, 1, 16'h7777, 0);
        vt[12] = mk(1, 2'b00, 12'hFFF, 16'h0000, 1, 2'b00, 12'h005, 16'h0000, 1, 1, 16'hAB11, 1, 1, 16'h1234, 0);
        vt[13] = mk(0, 2'b00, 12'h000, 16'h0000, 0, 2'b00, 12'h000, 16'h0000, 0, 1, 16'hAB11, 0, 1, 16'h1234, 0);
        vt[14] = mk(1, 2'b01, 12'h040, 16'h00CC, 1, 2'b10, 12'h040, 16'hDD00, 1, 0, 16'h0000, 1, 0, 16'h0000, 1);
        vt[15] = mk(1, 2'b00, 12'h040, 16'h0000, 0, 2'b00, 12'h000, 16'h0000, 1, 1, 16'hDDCC, 0, 0, 16'h0000, 0);
        vt[16] = mk(1, 2'b11, 12'h050, 16'h0001, 1, 2'b11, 12'h051, 16'h0002, 1, 0, 16'h0000, 1, 0, 16'h0000, 0);
        vt[17] = mk(1, 2'b00, 12'h051, 16'h0000, 1, 2'b00, 12'h050, 16'h0000, 1, 1, 16'h0002, 1, 1, 16'h0001, 0);

        // ---------------- reset state ----------------
        reset = 1'b1;
        idle();
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_a_read_i%0d", i),  32'(o_ar[i]), 32'd0);
            chk($sformatf("rst_b_read_i%0d", i),  32'(o_br[i]), 32'd0);
            chk($sformatf("rst_a_valid_i%0d", i), 32'(o_av[i]), 32'd0);
            chk($sformatf("rst_b_valid_i%0d", i), 32'(o_bv[i]), 32'd0);
            chk($sformatf("rst_collision_i%0d", i), 32'(o_col[i]), 32'd0);
        end
        reset = 1'b0;

`ifdef DPRAM_CLEAR_EN
        // Reset part-way through the clear restarts it from address 0
        repeat (8) step();
        chk("busy_mid_clear", 32'(o_busy[0]), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_clear(0);
        // Every word reads back as zero after the clear
        for (int ad = 0; ad < DEPTH; ad++) begin
            set_a(1'b1, 2'b00, 12'(ad), 16'h0000);
            step();
            if (o_av[0] !== 1'b1 || o_ar[0] !== 16'h0000) begin
                chk($sformatf("cleared_word_%03h", ad), {15'd0, o_av[0], o_ar[0]}, {15'd0, 1'b1, 16'h0000});
            end else begin
                checks++;
            end
        end
        idle();
        step();
`else
        wait_clear(0);
`endif

        // ---------------- vector table ----------------
        for (int k = 0; k < 18; k++) begin
            set_a(vt[k].a_ce, vt[k].a_we, vt[k].a_addr, vt[k].a_wr);
            set_b(vt[k].b_ce, vt[k].b_we, vt[k].b_addr, vt[k].b_wr);
            step();
            chk($sformatf("vec%0d_a_valid", k), 32'(o_av[0]), 32'(vt[k].e_av));
            if (vt[k].chk_ar) chk($sformatf("vec%0d_a_read", k), 32'(o_ar[0]), 32'(vt[k].e_ar));
            chk($sformatf("vec%0d_b_valid", k), 32'(o_bv[0]), 32'(vt[k].e_bv));
            if (vt[k].chk_br) chk($sformatf("vec%0d_b_read", k), 32'(o_br[0]), 32'(vt[k].e_br));
            chk($sformatf("vec%0d_collision", k), 32'(o_col[0]), 32'(vt[k].e_col));
        end
        idle();
        step();

        // ---------------- latency and read-during-write modes ----------------
        set_a(1'b1, 2'b00, 12'h005, 16'h0000);
        step();
        chk("lat1_i0_a_valid", 32'(o_av[0]), 32'd1);
        chk("lat1_i0_a_read",  32'(o_ar[0]), 32'h1234);
        chk("lat2_i1_a_valid_early", 32'(o_av[1]), 32'd0);
        chk("nc_i2_read_valid", 32'(o_av[2]), 32'd1);
        chk("nc_i2_read_data",  32'(o_ar[2]), 32'h1234);

        set_a(1'b1, 2'b11, 12'h010, 16'h1111);
        step();
        chk("lat2_i1_a_valid", 32'(o_av[1]), 32'd1);
        chk("lat2_i1_a_read",  32'(o_ar[1]), 32'h1234);
        chk("nc_i2_wr_valid",  32'(o_av[2]), 32'd0);
        chk("nc_i2_wr_hold",   32'(o_ar[2]), 32'h1234);

        set_a(1'b1, 2'b11, 12'h010, 16'h2222);
        step();
        chk("rf_i0_rdw_data",  32'(o_ar[0]), 32'h1111);
        chk("rf_i0_rdw_valid", 32'(o_av[0]), 32'd1);
        chk("nc_i2_rdw_valid", 32'(o_av[2]), 32'd0);
        chk("nc_i2_rdw_hold",  32'(o_ar[2]), 32'h1234);
        chk("wf_i1_first_write", 32'(o_ar[1]), 32'h1111);

        idle();
        step();
        chk("wf_i1_rdw_valid", 32'(o_av[1]), 32'd1);
        chk("wf_i1_rdw_data",  32'(o_ar[1]), 32'h2222);
        chk("rf_i0_idle_valid", 32'(o_av[0]), 32'd0);
        chk("rf_i0_idle_hold",  32'(o_ar[0]), 32'h1111);
        step();
        chk("oreg_i1_no_valid", 32'(o_av[1]), 32'd0);
        chk("oreg_i1_hold",     32'(o_ar[1]), 32'h2222);

        // ---------------- reset with reads in flight (OREG=1) ----------------
        set_a(1'b1, 2'b00, 12'h005, 16'h0000);
        set_b(1'b1, 2'b00, 12'hFFF, 16'h0000);
        step();
        idle();
        reset = 1'b1;
        step();
        chk("rst_flight_a_valid", 32'(o_av[1]), 32'd0);
        chk("rst_flight_b_valid", 32'(o_bv[1]), 32'd0);
        chk("rst_flight_a_read",  32'(o_ar[1]), 32'd0);
        chk("rst_flight_b_read",  32'(o_br[1]), 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_a_valid", 32'(o_av[1]), 32'd0);
        chk("post_rst_b_valid", 32'(o_bv[1]), 32'd0);
        chk("post_rst_a_read",  32'(o_ar[1]), 32'd0);
        chk("post_rst_b_read",  32'(o_br[1]), 32'd0);
        wait_clear(1);

        // ---------------- randomized phase against the model ----------------
        for (int n = 0; n < 400; n++) begin
            set_a(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3) > 1 ? $urandom_range(1, 3) : 0),
                  pool[$urandom_range(0, 6)], 16'($urandom));
            set_b(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3) > 1 ? $urandom_range(1, 3) : 0),
                  pool[$urandom_range(0, 6)], 16'($urandom));
            step();
            check_model();
        end
        idle();
        step();
        check_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
